// File: rtl/hv_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers
// (video generator, PPU register/NMI logic).
interface hv_timing_gen_if;
    logic       SKIP_EN;
    logic       PCLK;
    logic       n_PCLK;
    logic       PSTB;
    logic [8:0] H_out;
    logic [8:0] V_out;
    logic       HBLANK;
    logic       HSYNC;
    logic       BURST;
    logic       VBLANK;
    logic       VSYNC;
    logic       VBL_SET;
    logic       ODD;

    // Generator side: drives all timing, samples the rendering-enable.
    modport master (
        input  SKIP_EN,
        output PCLK, n_PCLK, PSTB, H_out, V_out,
        output HBLANK, HSYNC, BURST, VBLANK, VSYNC, VBL_SET, ODD
    );

    // Consumer side.
    modport slave (
        output SKIP_EN,
        input  PCLK, n_PCLK, PSTB, H_out, V_out,
        input  HBLANK, HSYNC, BURST, VBLANK, VSYNC, VBL_SET, ODD
    );
endinterface

// File: rtl/hv_timing_gen.sv
// Raster timing generator: pixel-clock divider, H/V counters with NTSC
// odd-frame short line, and registered H/V decodes aligned to the counters.
module hv_timing_gen #(
    parameter int PCLK_DIV      = 4,
    parameter int H_TOTAL       = 341,
    parameter int V_TOTAL       = 262,
    parameter int H_BLANK_START = 256,
    parameter int H_SYNC_START  = 277,
    parameter int H_SYNC_END    = 302,
    parameter int BURST_START   = 309,
    parameter int BURST_END     = 328,
    parameter int V_BLANK_START = 241,
    parameter int V_SYNC_START  = 244,
    parameter int ODD_SKIP      = 1
) (
    input  logic            CLK,
    input  logic            RES,
    hv_timing_gen_if.master tif
);

    localparam int DW = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;

    localparam logic [DW-1:0] D_LAST = DW'(PCLK_DIV - 1);
    // PCLK is high for the last PCLK_DIV/2 master cycles of the pixel.
    localparam logic [DW-1:0] D_HIGH = DW'(PCLK_DIV - PCLK_DIV / 2);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_SKIP = 9'(H_TOTAL - 2);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    // Decode bounds are one bit wider so an end bound of 512 still fits.
    localparam logic [9:0] HB_S = 10'(H_BLANK_START);
    localparam logic [9:0] HS_S = 10'(H_SYNC_START);
    localparam logic [9:0] HS_E = 10'(H_SYNC_END);
    localparam logic [9:0] BU_S = 10'(BURST_START);
    localparam logic [9:0] BU_E = 10'(BURST_END);
    localparam logic [9:0] VB_S = 10'(V_BLANK_START);
    localparam logic [9:0] VB_E = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_S = 10'(V_SYNC_START);
    localparam logic [9:0] VS_E = 10'(V_SYNC_START + 3);

    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [8:0]    h_reg, h_next;
    logic [8:0]    v_reg, v_next;
    logic          odd_reg, odd_next;
    logic          pclk_reg, pstb_reg;
    logic          hblank_reg, hsync_reg, burst_reg;
    logic          vblank_reg, vsync_reg, vbl_set_reg;
    logic          pix_end;
    logic          skip_hit;
    logic [9:0]    h_ext, v_ext;

    // Next-state for divider, counters and frame parity.
    always_comb begin
        pix_end   = (dcnt_reg == D_LAST);
        dcnt_next = pix_end ? '0 : dcnt_reg + 1'b1;
        skip_hit  = (ODD_SKIP != 0) && odd_reg && tif.SKIP_EN
                    && (v_reg == V_LAST) && (h_reg == H_SKIP);
        h_next    = h_reg;
        v_next    = v_reg;
        odd_next  = odd_reg;
        if (pix_end) begin
            if (skip_hit) begin
                // Short odd line: jump straight to (0,0), dropping one pixel.
                h_next   = '0;
                v_next   = '0;
                odd_next = ~odd_reg;
            end else if (h_reg == H_LAST) begin
                h_next = '0;
                if (v_reg == V_LAST) begin
                    v_next   = '0;
                    odd_next = ~odd_reg;
                end else begin
                    v_next = v_reg + 9'd1;
                end
            end else begin
                h_next = h_reg + 9'd1;
            end
        end
        h_ext = {1'b0, h_next};
        v_ext = {1'b0, v_next};
    end

    // State and decodes; decodes use next-state counters so they line up with H/V.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            dcnt_reg    <= '0;
            h_reg       <= '0;
            v_reg       <= '0;
            odd_reg     <= 1'b0;
            pclk_reg    <= 1'b0;
            pstb_reg    <= 1'b0;
            hblank_reg  <= 1'b0;
            hsync_reg   <= 1'b0;
            burst_reg   <= 1'b0;
            vblank_reg  <= 1'b0;
            vsync_reg   <= 1'b0;
            vbl_set_reg <= 1'b0;
        end else begin
            dcnt_reg    <= dcnt_next;
            h_reg       <= h_next;
            v_reg       <= v_next;
            odd_reg     <= odd_next;
            pclk_reg    <= (dcnt_next >= D_HIGH);
            pstb_reg    <= (dcnt_next == D_LAST);
            hblank_reg  <= (h_ext >= HB_S);
            hsync_reg   <= (h_ext >= HS_S) && (h_ext < HS_E);
            burst_reg   <= (h_ext >= BU_S) && (h_ext < BU_E);
            vblank_reg  <= (v_ext >= VB_S) && (v_ext < VB_E);
            vsync_reg   <= (v_ext >= VS_S) && (v_ext < VS_E);
            vbl_set_reg <= (v_ext == VB_S) && (h_ext == 10'd1);
        end
    end

    assign tif.PCLK    = pclk_reg;
    assign tif.n_PCLK  = ~pclk_reg;
    assign tif.PSTB    = pstb_reg;
    assign tif.H_out   = h_reg;
    assign tif.V_out   = v_reg;
    assign tif.HBLANK  = hblank_reg;
    assign tif.HSYNC   = hsync_reg;
    assign tif.BURST   = burst_reg;
    assign tif.VBLANK  = vblank_reg;
    assign tif.VSYNC   = vsync_reg;
    assign tif.VBL_SET = vbl_set_reg;
    assign tif.ODD     = odd_reg;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Bench for hv_timing_gen: two scaled rasters (NTSC-like with odd skip,
// PAL-like without) plus one default-parameter instance, all on one clock.
module tb_hv_timing_gen;

    // Index 0: scaled NTSC, 1: scaled PAL, 2: defaults.
    localparam int P_DIV [3] = '{4, 5, 4};
    localparam int P_HT  [3] = '{24, 20, 341};
    localparam int P_VT  [3] = '{14, 16, 262};
    localparam int P_HBS [3] = '{16, 14, 256};
    localparam int P_HSS [3] = '{18, 15, 277};
    localparam int P_HSE [3] = '{20, 17, 302};
    localparam int P_BS  [3] = '{21, 18, 309};
    localparam int P_BE  [3] = '{23, 19, 328};
    localparam int P_VBS [3] = '{10, 11, 241};
    localparam int P_VSS [3] = '{11, 12, 244};
    localparam int P_OS  [3] = '{1, 0, 1};

    localparam logic [27:0] RST_PACK = 28'h4000000;  // only n_PCLK high

    logic CLK = 1'b0;
    logic RES = 1'b1;
    logic skip_en = 1'b0;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    hv_timing_gen_if if_n ();
    hv_timing_gen_if if_p ();
    hv_timing_gen_if if_d ();

    assign if_n.SKIP_EN = skip_en;
    assign if_p.SKIP_EN = skip_en;
    assign if_d.SKIP_EN = skip_en;

    hv_timing_gen #(
        .PCLK_DIV(P_DIV[0]), .H_TOTAL(P_HT[0]), .V_TOTAL(P_VT[0]),
        .H_BLANK_START(P_HBS[0]), .H_SYNC_START(P_HSS[0]), .H_SYNC_END(P_HSE[0]),
        .BURST_START(P_BS[0]), .BURST_END(P_BE[0]),
        .V_BLANK_START(P_VBS[0]), .V_SYNC_START(P_VSS[0]), .ODD_SKIP(P_OS[0])
    ) u_ntsc (.CLK(CLK), .RES(RES), .tif(if_n));

    hv_timing_gen #(
        .PCLK_DIV(P_DIV[1]), .H_TOTAL(P_HT[1]), .V_TOTAL(P_VT[1]),
        .H_BLANK_START(P_HBS[1]), .H_SYNC_START(P_HSS[1]), .H_SYNC_END(P_HSE[1]),
        .BURST_START(P_BS[1]), .BURST_END(P_BE[1]),
        .V_BLANK_START(P_VBS[1]), .V_SYNC_START(P_VSS[1]), .ODD_SKIP(P_OS[1])
    ) u_pal (.CLK(CLK), .RES(RES), .tif(if_p));

    hv_timing_gen u_dflt (.CLK(CLK), .RES(RES), .tif(if_d));

    always #5 CLK = ~CLK;

    // Output layout: {PCLK, n_PCLK, PSTB, H[8:0], V[8:0], HB, HS, BU, VB, VS, VBL_SET, ODD}
    function automatic logic [27:0] pack_dut(int k);
        case (k)
            0: return {if_n.PCLK, if_n.n_PCLK, if_n.PSTB, if_n.H_out, if_n.V_out, if_n.HBLANK,
                       if_n.HSYNC, if_n.BURST, if_n.VBLANK, if_n.VSYNC, if_n.VBL_SET, if_n.ODD};
            1: return {if_p.PCLK, if_p.n_PCLK, if_p.PSTB, if_p.H_out, if_p.V_out, if_p.HBLANK,
                       if_p.HSYNC, if_p.BURST, if_p.VBLANK, if_p.VSYNC, if_p.VBL_SET, if_p.ODD};
            default: return {if_d.PCLK, if_d.n_PCLK, if_d.PSTB, if_d.H_out, if_d.V_out, if_d.HBLANK,
                       if_d.HSYNC, if_d.BURST, if_d.VBLANK, if_d.VSYNC, if_d.VBL_SET, if_d.ODD};
        endcase
    endfunction

    task automatic check(string name, logic [27:0] got, logic [27:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference model: raster position as a linear pixel index within the frame,
    // master cycles since reset, and frame parity.
    int m_t   [3] = '{0, 0, 0};
    int m_pos [3] = '{0, 0, 0};
    bit m_odd [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge CLK or posedge RES);
            for (int k = 0; k < 3; k++) begin
                if (RES) begin
                    m_t[k] = 0; m_pos[k] = 0; m_odd[k] = 0;
                end else begin
                    if (m_t[k] % P_DIV[k] == P_DIV[k] - 1) begin
                        int n;
                        n = P_HT[k] * P_VT[k];
                        if (P_OS[k] != 0 && m_odd[k] && skip_en && m_pos[k] == n - 2) begin
                            m_pos[k] = 0; m_odd[k] = !m_odd[k];
                        end else if (m_pos[k] == n - 1) begin
                            m_pos[k] = 0; m_odd[k] = !m_odd[k];
                        end else begin
                            m_pos[k] = m_pos[k] + 1;
                        end
                    end
                    m_t[k] = m_t[k] + 1;
                end
            end
        end
    end

    function automatic logic [27:0] exp_pack(int k);
        int h, v, d;
        bit pclk;
        h = m_pos[k] % P_HT[k];
        v = m_pos[k] / P_HT[k];
        d = m_t[k] % P_DIV[k];
        pclk = (d >= P_DIV[k] - P_DIV[k] / 2);
        return {pclk, !pclk, d == P_DIV[k] - 1, 9'(h), 9'(v),
                h >= P_HBS[k], (h >= P_HSS[k] && h < P_HSE[k]), (h >= P_BS[k] && h < P_BE[k]),
                (v >= P_VBS[k] && v < P_VT[k] - 1), (v >= P_VSS[k] && v < P_VSS[k] + 3),
                (v == P_VBS[k] && h == 1), m_odd[k]};
    endfunction

    // Frame-length and VBL_SET-width measurement for the two scaled rasters.
    typedef struct { int len; bit odd; } frame_t;
    frame_t fq0[$];
    frame_t fq1[$];
    int vq0[$];
    int vq1[$];
    bit prev_zero  [2] = '{0, 0};
    bit have_start [2] = '{0, 0};
    int start_cyc  [2] = '{0, 0};
    bit frame_odd  [2] = '{0, 0};
    int vbl_run    [2] = '{0, 0};

    task automatic track(int k, logic [27:0] o);
        bit zero;
        frame_t f;
        zero = (o[24:16] == 9'd0) && (o[15:7] == 9'd0);
        if (zero && !prev_zero[k]) begin
            if (have_start[k]) begin
                f.len = (cyc - start_cyc[k]) / P_DIV[k];
                f.odd = frame_odd[k];
                if (k == 0) fq0.push_back(f); else fq1.push_back(f);
                $display("frame dut%0d pixels=%0d odd=%0d", k, f.len, f.odd);
            end
            have_start[k] = 1;
            start_cyc[k]  = cyc;
            frame_odd[k]  = o[0];
        end
        prev_zero[k] = zero;
        if (o[1]) begin
            vbl_run[k]++;
        end else if (vbl_run[k] != 0) begin
            if (k == 0) vq0.push_back(vbl_run[k]); else vq1.push_back(vbl_run[k]);
            vbl_run[k] = 0;
        end
    endtask

    task automatic clear_track();
        fq0.delete();
        fq1.delete();
        have_start[0] = 0;
        have_start[1] = 0;
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    logic [27:0] o;
                    o = pack_dut(k);
                    check($sformatf("model_dut%0d", k), o, exp_pack(k));
                    if (k < 2) track(k, o);
                end
            end
        end
    end

    // Startup vectors: master edges since release vs PCLK/PSTB/H.
    typedef struct {
        int e;
        bit pclk0; bit pstb0; int h0;
        bit pclk1; bit pstb1; int h1;
    } su_t;
    su_t su_tab[11];

    task automatic run_startup();
        RES = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) #1; else @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                logic [27:0] ex;
                if (k == 1)
                    ex = {su_tab[i].pclk1, !su_tab[i].pclk1, su_tab[i].pstb1, 9'(su_tab[i].h1), 16'd0};
                else
                    ex = {su_tab[i].pclk0, !su_tab[i].pclk0, su_tab[i].pstb0, 9'(su_tab[i].h0), 16'd0};
                check($sformatf("startup_e%0d_dut%0d", su_tab[i].e, k), pack_dut(k), ex);
            end
            $display("startup e=%0d ntsc=%h pal=%h", su_tab[i].e, pack_dut(0), pack_dut(1));
        end
    endtask

    initial begin
        int w;
        su_tab[0]  = '{0,  0, 0, 0, 0, 0, 0};
        su_tab[1]  = '{1,  0, 0, 0, 0, 0, 0};
        su_tab[2]  = '{2,  1, 0, 0, 0, 0, 0};
        su_tab[3]  = '{3,  1, 1, 0, 1, 0, 0};
        su_tab[4]  = '{4,  0, 0, 1, 1, 1, 0};
        su_tab[5]  = '{5,  0, 0, 1, 0, 0, 1};
        su_tab[6]  = '{6,  1, 0, 1, 0, 0, 1};
        su_tab[7]  = '{7,  1, 1, 1, 0, 0, 1};
        su_tab[8]  = '{8,  0, 0, 2, 1, 0, 1};
        su_tab[9]  = '{9,  0, 0, 2, 1, 1, 1};
        su_tab[10] = '{10, 1, 0, 2, 0, 0, 2};

        // Reset held for 10 clocks.
        repeat (10) @(negedge CLK);
        for (int k = 0; k < 3; k++) check($sformatf("reset_dut%0d", k), pack_dut(k), RST_PACK);
        $display("reset hold ntsc=%h pal=%h dflt=%h", pack_dut(0), pack_dut(1), pack_dut(2));
        run_startup();

        // Random SKIP_EN toggling with full model comparison.
        chk_en = 1'b1;
        repeat (6000) begin
            @(negedge CLK);
            skip_en = 1'($urandom_range(0, 1));
        end

        // SKIP_EN held high: odd frames one pixel short, parity alternates.
        @(negedge CLK);
        skip_en = 1'b1;
        clear_track();
        w = 0;
        while (fq0.size() < 4 && w < 8000) begin @(negedge CLK); w++; end
        check_int("skip_on_frames_seen", (fq0.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < fq0.size(); i++) begin
            check_int($sformatf("skip_on_len%0d", i), fq0[i].len,
                      fq0[i].odd ? P_HT[0] * P_VT[0] - 1 : P_HT[0] * P_VT[0]);
            if (i > 0) check_int($sformatf("skip_on_odd_toggle%0d", i),
                                 int'(fq0[i].odd != fq0[i-1].odd), 1);
        end
        check_int("pal_frames_seen", (fq1.size() >= 2) ? 1 : 0, 1);
        for (int i = 0; i < fq1.size(); i++)
            check_int($sformatf("pal_len%0d", i), fq1[i].len, P_HT[1] * P_VT[1]);

        // SKIP_EN low: every frame full length.
        skip_en = 1'b0;
        clear_track();
        w = 0;
        while (fq0.size() < 2 && w < 4500) begin @(negedge CLK); w++; end
        check_int("skip_off_frames_seen", (fq0.size() >= 2) ? 1 : 0, 1);
        for (int i = 0; i < fq0.size(); i++)
            check_int($sformatf("skip_off_len%0d", i), fq0[i].len, P_HT[0] * P_VT[0]);

        // VBL_SET pulse width in master clocks.
        check_int("vbl_set_seen", (vq0.size() > 0 && vq1.size() > 0) ? 1 : 0, 1);
        foreach (vq0[i]) check_int($sformatf("vbl_width_ntsc%0d", i), vq0[i], P_DIV[0]);
        foreach (vq1[i]) check_int($sformatf("vbl_width_pal%0d", i), vq1[i], P_DIV[1]);

        // Asynchronous reset mid-frame, between clock edges.
        w = 0;
        while (!(if_n.V_out == 9'd7 && if_n.H_out == 9'd12) && w < 2000) begin
            @(negedge CLK); w++;
        end
        check_int("async_target_reached", (w < 2000) ? 1 : 0, 1);
        chk_en = 1'b0;
        #1 RES = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("async_reset_dut%0d", k), pack_dut(k), RST_PACK);
        $display("async reset ntsc=%h pal=%h dflt=%h", pack_dut(0), pack_dut(1), pack_dut(2));
        repeat (3) @(negedge CLK);
        run_startup();

        chk_en = 1'b1;
        repeat (2000) begin
            @(negedge CLK);
            skip_en = 1'($urandom_range(0, 1));
        end
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
